// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard port: queues scancode events from the ps2 decoder in a FIFO and
// exposes DATA/STATUS registers plus a level interrupt to the 68000 bus.
module ps2_kbd_port #(
    parameter int c_depth_bits = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        cs,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic        lb,
    input  logic [7:0]  din,
    output logic [15:0] dout,
    output logic        irq
);
    localparam int DEPTH = 1 << c_depth_bits;
    localparam logic [c_depth_bits-1:0] PTR_ONE = 1;
    localparam logic [c_depth_bits:0]   CNT_ONE = 1;

    logic [9:0]              mem [DEPTH];
    logic [c_depth_bits-1:0] rd_ptr;
    logic [c_depth_bits-1:0] wr_ptr;
    logic [c_depth_bits:0]   count;
    logic [c_depth_bits:0]   count_nxt;
    logic overflow, irq_en, pop_pend, tog_q, cs_q;
    logic acc_start, acc_end, push_req, reg_wr, flush, pop;
    logic full, nonempty, push_ok, ovf_set;

    always_comb begin
        acc_start = cs & ~cs_q;
        acc_end   = ~cs & cs_q;
        push_req  = ps2_key[10] ^ tog_q;
        reg_wr    = acc_start & ~rw & (addr == 2'd1) & lb;
        flush     = reg_wr & din[1];
        pop       = acc_end & pop_pend;
        // count only ever reaches DEPTH, so its top bit alone means full
        full      = count[c_depth_bits];
        nonempty  = |count;
        // a pop in the same cycle frees the slot a full FIFO needs
        push_ok   = push_req & (~full | pop) & ~flush;
        ovf_set   = push_req & full & ~pop & ~flush;

        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push_ok & ~pop)
            count_nxt = count + CNT_ONE;
        else if (pop & ~push_ok)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            pop_pend <= 1'b0;
            cs_q     <= 1'b1;
            irq      <= 1'b0;
        end else begin
            cs_q  <= cs;
            count <= count_nxt;
            irq   <= irq_en & nonempty;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (reg_wr) irq_en <= din[0];
            overflow <= (overflow & ~(reg_wr & din[2])) | ovf_set;
            if (flush | pop)
                pop_pend <= 1'b0;
            else if (acc_start & rw & (addr == 2'd0) & nonempty)
                pop_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok & ~reset) mem[wr_ptr] <= ps2_key[9:0];
    end

    always_comb begin
        dout = '0;
        if (cs) begin
            case (addr)
                2'd0: begin
                    dout[15] = nonempty;
                    dout[14] = overflow;
                    if (nonempty) dout[9:0] = mem[rd_ptr];
                end
                2'd1: begin
                    dout[15] = nonempty;
                    dout[14] = overflow;
                    dout[13] = irq_en;
                    dout[c_depth_bits:0] = count;
                end
                default: dout = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_kbd_port.sv
// Bench for ps2_kbd_port: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ps2_kbd_port;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        cs, rw, lb;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [15:0] dout;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit live     = 0;

    ps2_kbd_port #(.c_depth_bits(4)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .cs(cs), .rw(rw),
        .addr(addr), .lb(lb), .din(din), .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [9:0] mq[$];
    bit m_ovf = 0, m_en = 0, m_pend = 0, m_tog = 0, m_csq = 1, m_irq = 0;

    function automatic logic [15:0] exp_dout();
        logic [15:0] e;
        e = '0;
        if (cs) begin
            if (addr == 2'd0) begin
                e[15] = (mq.size() != 0);
                e[14] = m_ovf;
                if (mq.size() != 0) e[9:0] = mq[0];
            end else if (addr == 2'd1) begin
                e[15] = (mq.size() != 0);
                e[14] = m_ovf;
                e[13] = m_en;
                e[4:0] = 5'(mq.size());
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        int sz;
        bit st, en_, push_r, wr, fl, pp;
        sz = mq.size();
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_en = 0; m_pend = 0; m_csq = 1; m_irq = 0;
        end else begin
            st     = cs && !m_csq;
            en_    = !cs && m_csq;
            push_r = (ps2_key[10] != m_tog);
            wr     = st && !rw && addr == 2'd1 && lb;
            fl     = wr && din[1];
            pp     = en_ && m_pend;
            m_irq  = m_en && sz != 0;
            if (pp) begin
                void'(mq.pop_front());
                m_pend = 0;
            end
            if (wr) begin
                m_en = din[0];
                if (din[2]) m_ovf = 0;
            end
            if (fl) begin
                mq.delete();
                m_pend = 0;
            end else if (push_r) begin
                if (mq.size() < DEPTH) mq.push_back(ps2_key[9:0]);
                else m_ovf = 1;
            end
            if (st && rw && addr == 2'd0 && sz != 0) m_pend = 1;
            m_csq = cs;
        end
        m_tog = ps2_key[10];
        #1;
        if (live) begin
            n_checks++;
            if (dout !== exp_dout()) begin
                n_fail++;
                $display("FAIL model_dout t=%0t: got %h expected %h", $time, dout, exp_dout());
            end
            n_checks++;
            if (irq !== m_irq) begin
                n_fail++;
                $display("FAIL model_irq t=%0t: got %b expected %b", $time, irq, m_irq);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [9:0] v);
        @(negedge clk);
        ps2_key = {~ps2_key[10], v};
    endtask

    task automatic bus(input logic r, input logic [1:0] a, input logic [7:0] d,
                       input int hold, output logic [15:0] rd);
        @(negedge clk);
        cs = 1'b1; rw = r; addr = a; lb = 1'b1; din = d;
        #1 rd = dout;
        repeat (hold) @(negedge clk);
        cs = 1'b0; lb = 1'b0; rw = 1'b1;
    endtask

    initial begin
        logic [15:0] rd;
        reset = 1'b1; ps2_key = '0; cs = 1'b0; rw = 1'b1; lb = 1'b0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        live = 1;
        reset = 1'b0;

        bus(1, 2'd1, 8'h00, 1, rd);  chk("reset_status", rd, 16'h0000);
        chk("reset_irq", {15'd0, irq}, 16'h0000);

        // push and read
        push({1'b1, 1'b0, 8'h1C});
        bus(1, 2'd1, 8'h00, 1, rd);  chk("push_status", rd, 16'h8001);
        bus(1, 2'd0, 8'h00, 1, rd);  chk("push_data", rd, 16'h821C);
        bus(1, 2'd1, 8'h00, 1, rd);  chk("after_read_status", rd, 16'h0000);

        // order, overflow, wrap
        for (int i = 1; i <= 20; i++) push(10'(i));
        bus(1, 2'd1, 8'h00, 1, rd);  chk("full_status", rd, 16'hC010);
        for (int i = 1; i <= 16; i++) begin
            bus(1, 2'd0, 8'h00, 1, rd);
            chk("order_data", rd, 16'hC000 | 16'(i));
        end
        for (int i = 0; i < 3; i++) push(10'h21 + 10'(i));
        for (int i = 0; i < 3; i++) begin
            bus(1, 2'd0, 8'h00, 1, rd);
            chk("wrap_data", rd, 16'hC021 + 16'(i));
        end
        bus(0, 2'd1, 8'h04, 1, rd);
        bus(1, 2'd1, 8'h00, 1, rd);  chk("ovf_clear_status", rd, 16'h0000);

        // interrupt
        bus(0, 2'd1, 8'h01, 1, rd);
        bus(1, 2'd1, 8'h00, 1, rd);  chk("irq_en_status", rd, 16'h2000);
        repeat (2) @(negedge clk);
        chk("irq_idle", {15'd0, irq}, 16'h0000);
        push(10'h077);
        @(posedge clk); #1 chk("irq_n", {15'd0, irq}, 16'h0000);
        @(posedge clk); #1 chk("irq_n1", {15'd0, irq}, 16'h0001);
        bus(1, 2'd0, 8'h00, 1, rd);  chk("irq_data", rd, 16'h8077);
        @(posedge clk); #1 chk("irq_end", {15'd0, irq}, 16'h0001);
        @(posedge clk); #1 chk("irq_fall", {15'd0, irq}, 16'h0000);
        bus(0, 2'd1, 8'h00, 1, rd);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(10'h030 + 10'(i));
        @(negedge clk); cs = 1; rw = 1; addr = 0; lb = 1;
        @(negedge clk); cs = 0; lb = 0; ps2_key = {~ps2_key[10], 10'h155};
        bus(1, 2'd1, 8'h00, 1, rd);  chk("pushpop_status", rd, 16'h8010);
        for (int i = 1; i <= 15; i++) begin
            bus(1, 2'd0, 8'h00, 1, rd);
            chk("pushpop_data", rd, 16'h8030 + 16'(i));
        end
        bus(1, 2'd0, 8'h00, 1, rd);  chk("pushpop_last", rd, 16'h8155);

        // long read and empty read
        push(10'h041); push(10'h042);
        bus(1, 2'd0, 8'h00, 10, rd); chk("long_data", rd, 16'h8041);
        bus(1, 2'd1, 8'h00, 1, rd);  chk("long_status", rd, 16'h8001);
        bus(1, 2'd0, 8'h00, 1, rd);  chk("long_data2", rd, 16'h8042);
        bus(1, 2'd0, 8'h00, 1, rd);  chk("empty_data", rd, 16'h0000);
        bus(1, 2'd1, 8'h00, 1, rd);  chk("empty_status", rd, 16'h0000);

        // flush with simultaneous push, overflow pending
        for (int i = 0; i < 17; i++) push(10'h050 + 10'(i));
        @(negedge clk); cs = 1; rw = 0; addr = 1; lb = 1; din = 8'h06;
        ps2_key = {~ps2_key[10], 10'h0EE};
        @(negedge clk); cs = 0; lb = 0; rw = 1;
        bus(1, 2'd1, 8'h00, 1, rd);  chk("flush_status", rd, 16'h0000);

        // reset in the middle of a read
        push(10'h060); push(10'h061);
        @(negedge clk); cs = 1; rw = 1; addr = 0; lb = 1;
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        push(10'h062);
        repeat (2) @(negedge clk);
        cs = 0; lb = 0;
        repeat (2) @(negedge clk);
        bus(1, 2'd1, 8'h00, 1, rd);  chk("rst_mid_status", rd, 16'h8001);
        bus(1, 2'd0, 8'h00, 1, rd);  chk("rst_mid_data", rd, 16'h8062);
        bus(1, 2'd1, 8'h00, 1, rd);  chk("rst_mid_after", rd, 16'h0000);

        // randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            cs    = ($urandom_range(0, 2) != 0);
            rw    = $urandom_range(0, 1) == 1;
            addr  = 2'($urandom_range(0, 3));
            lb    = ($urandom_range(0, 3) != 0);
            din   = 8'($urandom) & 8'hFD;
            if ($urandom_range(0, 7) == 0) din[1] = 1'b1;
            if ($urandom_range(0, 9) < 6)
                ps2_key = {~ps2_key[10], 10'($urandom)};
            else
                ps2_key[9:0] = 10'($urandom);
        end
        @(negedge clk); reset = 0; cs = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
